of_writeback: RTL

- Consumer end of the accelerator result interface. Captures each result row (SYS_COLS partial sums) when the array signals a row is ready.
- Buffers rows in a small FIFO and serialises them, one column per transfer, into the output-feature-map memory write port with address generation.
- Sits between the array top-level (result/ready) and the OF buffer/memory. Reports completion once a configured number of rows has been written.

---
 rtl/of_writeback_if.sv | 33 +++
 rtl/of_writeback.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/of_writeback_if.sv
// ============================================================================
// Module      : of_writeback_if
// Description : Result-row stream and memory write port of the OF writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface of_writeback_if #(
    parameter int SYS_COLS   = 8,
    parameter int P_BITWIDTH = 32,
    parameter int ADDR_W     = 16
);
    logic                           in_valid;
    logic [SYS_COLS*P_BITWIDTH-1:0] in_row;
    logic                           in_ready;
    logic                           mem_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic [P_BITWIDTH-1:0]          mem_wdata;
    logic                           mem_gnt;

    // master: the writeback block; slave: the array and memory around it
    modport master (
        input  in_valid, in_row, mem_gnt,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_row, mem_gnt,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/of_writeback.sv
// ============================================================================
// Module      : of_writeback
// Description : Captures result rows into a FIFO and serialises them, one
//               column per write, into the OF memory. Optional macro
//               OF_WRITEBACK_RELU_EN clamps negative words to zero on output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module of_writeback #(
    parameter int SYS_COLS   = 8,
    parameter int P_BITWIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              cfg_start,
    input  wire logic [ADDR_W-1:0] cfg_base,
    input  wire logic [ADDR_W-1:0] cfg_rows,
    of_writeback_if.master         bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int COL_W = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(SYS_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                                r_state;
    logic [SYS_COLS*P_BITWIDTH-1:0]        r_fifo [DEPTH];
    logic [PTR_W:0]                        r_wptr;
    logic [PTR_W:0]                        r_rptr;
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0]   r_shadow;
    logic [COL_W-1:0]                      r_col;
    logic [ADDR_W-1:0]                     r_row_cnt;
    logic [ADDR_W-1:0]                     r_rows;
    logic [ADDR_W-1:0]                     r_addr;
    logic                                  r_busy;
    logic                                  r_done;
    logic                                  r_overflow;

    logic                                  w_full;
    logic                                  w_empty;
    logic                                  w_push;
    logic                                  w_pop;
    logic [ADDR_W-1:0]                     w_row_next;
    logic [P_BITWIDTH-1:0]                 w_word;

    // Extra pointer bit distinguishes full from empty
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                        (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_push     = bus.in_valid && !w_full;
    assign w_pop      = (r_state == S_LOAD) && !w_empty;
    assign w_row_next = r_row_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[PTR_W-1:0]] <= bus.in_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (bus.in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Rows of a job are contiguous, so the address simply advances per grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shadow  <= '0;
            r_col     <= '0;
            r_row_cnt <= '0;
            r_rows    <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_rows    <= cfg_rows;
                        r_addr    <= cfg_base;
                        r_row_cnt <= '0;
                        r_col     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= (cfg_rows == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!w_empty) begin
                        r_shadow <= r_fifo[r_rptr[PTR_W-1:0]];
                        r_col    <= '0;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_gnt) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_col == C_LAST_COL) begin
                            r_col     <= '0;
                            r_row_cnt <= w_row_next;
                            r_state   <= (w_row_next == r_rows) ? S_DONE : S_LOAD;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_word = r_shadow[r_col];

`ifdef OF_WRITEBACK_RELU_EN
    assign bus.mem_wdata = w_word[P_BITWIDTH-1] ? '0 : w_word;
`else
    assign bus.mem_wdata = w_word;
`endif

    assign bus.in_ready = !w_full;
    assign bus.mem_we   = (r_state == S_WRITE);
    assign bus.mem_addr = r_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire
